mem_bus_arbiter: RTL

//  Shares one Wishbone-style system bus between the instruction side (ICACHE/IMMU, master 0)
//  and the data side (DCACHE/DMMU, master 1) of the MIPS core.

---
 rtl/mem_bus_arbiter_if.sv | 34 +++
 rtl/mem_bus_arbiter.sv | 89 ++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two core-side masters, the arbiter and the system bus.
// The master modport is the environment side; the slave modport is the arbiter side.
interface mem_bus_arbiter_if;
    logic        m0_cyc, m0_stb, m0_we;
    logic [3:0]  m0_sel;
    logic [31:0] m0_addr, m0_dout;
    logic        m0_ack, m0_err;
    logic        m1_cyc, m1_stb, m1_we;
    logic [3:0]  m1_sel;
    logic [31:0] m1_addr, m1_dout;
    logic        m1_ack, m1_err;
    logic [31:0] m_din;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_addr, wb_dout, wb_din;
    logic        wb_ack, wb_err;
    logic [1:0]  grant;

    modport master (
        output m0_cyc, m0_stb, m0_we, m0_sel, m0_addr, m0_dout,
        output m1_cyc, m1_stb, m1_we, m1_sel, m1_addr, m1_dout,
        output wb_din, wb_ack, wb_err,
        input  m0_ack, m0_err, m1_ack, m1_err, m_din,
        input  wb_cyc, wb_stb, wb_we, wb_sel, wb_addr, wb_dout, grant
    );

    modport slave (
        input  m0_cyc, m0_stb, m0_we, m0_sel, m0_addr, m0_dout,
        input  m1_cyc, m1_stb, m1_we, m1_sel, m1_addr, m1_dout,
        input  wb_din, wb_ack, wb_err,
        output m0_ack, m0_err, m1_ack, m1_err, m_din,
        output wb_cyc, wb_stb, wb_we, wb_sel, wb_addr, wb_dout, grant
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master Wishbone arbiter (m0 = instruction side, m1 = data side), owner held for a whole cycle.
// Define ARB_TIMEOUT_EN to build the hung-slave watchdog that forces a bus error after TIMEOUT cycles.
module mem_bus_arbiter #(
    parameter int TIMEOUT_BITS = 8,
    parameter int TIMEOUT      = 200
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_arbiter_if.slave   bus
);
    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} owner_t;

    owner_t owner, owner_nxt;
    logic   own0, own1;
    logic   to_hit;

    always_ff @(posedge clk) begin
        if (rst) owner <= IDLE;
        else     owner <= owner_nxt;
    end

    // Release always hands over to a waiting peer before the releasing side can re-win.
    always_comb begin
        owner_nxt = owner;
        case (owner)
            IDLE: begin
                if (bus.m1_cyc)      owner_nxt = OWN1;
                else if (bus.m0_cyc) owner_nxt = OWN0;
            end
            OWN0: if (!bus.m0_cyc) owner_nxt = bus.m1_cyc ? OWN1 : IDLE;
            OWN1: if (!bus.m1_cyc) owner_nxt = bus.m0_cyc ? OWN0 : IDLE;
            default: owner_nxt = IDLE;
        endcase
    end

    assign own0      = (owner == OWN0);
    assign own1      = (owner == OWN1);
    assign bus.grant = owner;
    assign bus.m_din = bus.wb_din;

    always_comb begin
        bus.wb_cyc  = 1'b0;
        bus.wb_stb  = 1'b0;
        bus.wb_we   = 1'b0;
        bus.wb_sel  = 4'h0;
        bus.wb_addr = 32'h0;
        bus.wb_dout = 32'h0;
        if (own0) begin
            bus.wb_cyc  = bus.m0_cyc;
            bus.wb_stb  = bus.m0_stb;
            bus.wb_we   = bus.m0_we;
            bus.wb_sel  = bus.m0_sel;
            bus.wb_addr = bus.m0_addr;
            bus.wb_dout = bus.m0_dout;
        end else if (own1) begin
            bus.wb_cyc  = bus.m1_cyc;
            bus.wb_stb  = bus.m1_stb;
            bus.wb_we   = bus.m1_we;
            bus.wb_sel  = bus.m1_sel;
            bus.wb_addr = bus.m1_addr;
            bus.wb_dout = bus.m1_dout;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_BITS-1:0] TO_VAL = TIMEOUT[TIMEOUT_BITS-1:0];
    logic [TIMEOUT_BITS-1:0] to_cnt;

    assign to_hit = (to_cnt == TO_VAL);

    always_ff @(posedge clk) begin
        if (rst)
            to_cnt <= '0;
        else if (!bus.wb_stb || bus.wb_ack || bus.wb_err || to_hit || (owner_nxt != owner))
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end
`else
    assign to_hit = 1'b0;
`endif

    // Responses are masked during reset so an aborted beat is never acknowledged.
    assign bus.m0_ack = !rst & own0 & bus.m0_stb & bus.wb_ack;
    assign bus.m1_ack = !rst & own1 & bus.m1_stb & bus.wb_ack;
    assign bus.m0_err = !rst & own0 & bus.m0_stb & (bus.wb_err | to_hit);
    assign bus.m1_err = !rst & own1 & bus.m1_stb & (bus.wb_err | to_hit);
endmodule
